// File: rtl/wb_arb_pkg.sv
// Shared definitions for the QoS Wishbone arbiter: FSM states, arbitration
// mode encodings and the watchdog counter width.
package wb_arb_pkg;

  localparam int unsigned MODE_RR    = 0;
  localparam int unsigned MODE_FIXED = 1;
  localparam int unsigned WDOG_W     = 16;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StTmo
  } arb_state_e;

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational winner selection: round-robin (first requester after last,
// wrapping) or fixed priority (lowest index).
module wb_arb_pick #(
  parameter int unsigned NumMasters = 2,
  parameter int unsigned IdxW       = 1
) (
  input  logic [NumMasters-1:0] req_i,
  input  logic [IdxW-1:0]       last_i,
  input  logic                  mode_i,
  output logic                  valid_o,
  output logic [IdxW-1:0]       idx_o
);

  logic [2*NumMasters-1:0] dbl;
  logic [NumMasters-1:0]   rot;
  int unsigned             start;
  int unsigned             hit;

  always_comb begin
    dbl     = {req_i, req_i};
    start   = (32'(last_i) + 1 >= NumMasters) ? 0 : 32'(last_i) + 1;
    // Rotating the doubled vector puts the RR start position at bit 0.
    rot     = NumMasters'(dbl >> start);
    valid_o = |req_i;
    hit     = 0;
    if (mode_i) begin
      for (int i = NumMasters - 1; i >= 0; i--) begin
        if (req_i[i]) hit = i;
      end
    end else begin
      for (int i = NumMasters - 1; i >= 0; i--) begin
        if (rot[i]) hit = i;
      end
      hit = hit + start;
      if (hit >= NumMasters) hit = hit - NumMasters;
    end
    idx_o = IdxW'(hit);
  end

endmodule

// File: rtl/wb_arbiter_qos.sv
// Wishbone B4 N-to-1 arbiter with selectable RR/fixed-priority arbitration and a
// per-transaction watchdog that errors out a stalled cycle to its owner.
module wb_arbiter_qos
  import wb_arb_pkg::*;
#(
  parameter int unsigned dw             = 32,
  parameter int unsigned aw             = 32,
  parameter int unsigned num_masters    = 2,
  parameter int unsigned mode           = MODE_RR,
  parameter int unsigned timeout_cycles = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [num_masters*aw-1:0]   wbm_adr_i,
  input  logic [num_masters*dw-1:0]   wbm_dat_i,
  input  logic [num_masters*dw/8-1:0] wbm_sel_i,
  input  logic [num_masters-1:0]      wbm_we_i,
  input  logic [num_masters-1:0]      wbm_cyc_i,
  input  logic [num_masters-1:0]      wbm_stb_i,
  input  logic [num_masters*3-1:0]    wbm_cti_i,
  input  logic [num_masters*2-1:0]    wbm_bte_i,
  output logic [num_masters*dw-1:0]   wbm_dat_o,
  output logic [num_masters-1:0]      wbm_ack_o,
  output logic [num_masters-1:0]      wbm_err_o,
  output logic [num_masters-1:0]      wbm_rty_o,
  output logic [aw-1:0]               wbs_adr_o,
  output logic [dw-1:0]               wbs_dat_o,
  output logic [dw/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [dw-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  output logic [num_masters-1:0]      grant_o,
  output logic                        timeout_o
);

  localparam int unsigned SelW = dw / 8;
  localparam int unsigned IdxW = (num_masters > 1) ? $clog2(num_masters) : 1;
  localparam logic [WDOG_W:0] TmoLimit = (WDOG_W + 1)'(timeout_cycles);
  localparam bit WdogEn    = (timeout_cycles != 0);
  localparam bit ModeFixed = (mode == MODE_FIXED);

  arb_state_e              state_q, state_d;
  logic [IdxW-1:0]         owner_q, owner_d;
  logic [IdxW-1:0]         last_q, last_d;
  logic [WDOG_W-1:0]       cnt_q, cnt_d;
  logic [WDOG_W:0]         cnt_inc;
  logic [num_masters-1:0]  owner_oh;
  logic                    own_cyc, own_stb, slv_rsp, busy;
  logic                    pick_valid;
  logic [IdxW-1:0]         pick_idx;

  wb_arb_pick #(
    .NumMasters (num_masters),
    .IdxW       (IdxW)
  ) u_pick (
    .req_i   (wbm_cyc_i),
    .last_i  (last_q),
    .mode_i  (ModeFixed),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Owner decode and slave-side mux; idle shows the last owner's inputs.
  always_comb begin
    owner_oh  = '0;
    wbs_adr_o = wbm_adr_i[aw-1:0];
    wbs_dat_o = wbm_dat_i[dw-1:0];
    wbs_sel_o = wbm_sel_i[SelW-1:0];
    wbs_we_o  = wbm_we_i[0];
    wbs_cti_o = wbm_cti_i[2:0];
    wbs_bte_o = wbm_bte_i[1:0];
    for (int i = 0; i < num_masters; i++) begin
      if (owner_q == IdxW'(i)) begin
        owner_oh[i] = 1'b1;
        wbs_adr_o   = wbm_adr_i[i*aw +: aw];
        wbs_dat_o   = wbm_dat_i[i*dw +: dw];
        wbs_sel_o   = wbm_sel_i[i*SelW +: SelW];
        wbs_we_o    = wbm_we_i[i];
        wbs_cti_o   = wbm_cti_i[i*3 +: 3];
        wbs_bte_o   = wbm_bte_i[i*2 +: 2];
      end
    end
  end

  always_comb begin
    busy      = (state_q == StBusy);
    own_cyc   = |(owner_oh & wbm_cyc_i);
    own_stb   = |(owner_oh & wbm_stb_i);
    slv_rsp   = wbs_ack_i | wbs_err_i | wbs_rty_i;
    wbs_cyc_o = busy & own_cyc;
    wbs_stb_o = busy & own_stb;
    wbm_dat_o = {num_masters{wbs_dat_i}};
    wbm_ack_o = busy ? (owner_oh & {num_masters{wbs_ack_i}}) : '0;
    wbm_rty_o = busy ? (owner_oh & {num_masters{wbs_rty_i}}) : '0;
    wbm_err_o = '0;
    if (busy) begin
      wbm_err_o = owner_oh & {num_masters{wbs_err_i}};
    end else if (state_q == StTmo) begin
      wbm_err_o = owner_oh;
    end
    grant_o   = (state_q == StIdle) ? '0 : owner_oh;
    timeout_o = (state_q == StTmo);
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    cnt_inc = {1'b0, cnt_q} + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        // Owner release beats a response, which beats the watchdog.
        if (!own_cyc) begin
          last_d  = owner_q;
          state_d = StIdle;
        end else if (slv_rsp) begin
          cnt_d = '0;
        end else if (own_stb) begin
          cnt_d = cnt_inc[WDOG_W-1:0];
          if (WdogEn && (cnt_inc == TmoLimit)) state_d = StTmo;
        end
      end
      StTmo: begin
        last_d  = owner_q;
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= IdxW'(num_masters - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_qos.sv
// Directed bench: RR and fixed-priority arbitration, watchdog corner cases,
// mid-transaction reset and a single-master 64-bit instance.
module tb_wb_arbiter_qos;

  localparam int unsigned N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Master-side stimulus shared by the two 3-master instances.
  logic [N*32-1:0] m_adr, m_dat;
  logic [N*4-1:0]  m_sel;
  logic [N-1:0]    m_we, m_cyc, m_stb;
  logic [N*3-1:0]  m_cti;
  logic [N*2-1:0]  m_bte;

  // Instance A: round-robin, timeout_cycles = 4
  logic [N*32-1:0] a_mdat;
  logic [N-1:0]    a_ack, a_err, a_rty, a_grant;
  logic [31:0]     a_adr, a_wdat, a_sdat;
  logic [3:0]      a_sel;
  logic            a_we, a_cyc, a_stb, a_tmo, a_sack, a_serr, a_srty;
  logic [2:0]      a_cti;
  logic [1:0]      a_bte;

  // Instance B: fixed priority, watchdog off
  logic [N*32-1:0] b_mdat;
  logic [N-1:0]    b_ack, b_err, b_rty, b_grant;
  logic [31:0]     b_adr, b_wdat, b_sdat;
  logic [3:0]      b_sel;
  logic            b_we, b_cyc, b_stb, b_tmo, b_sack, b_serr, b_srty;
  logic [2:0]      b_cti;
  logic [1:0]      b_bte;

  // Instance C: dw = 64, one master, watchdog off
  logic [31:0] c_madr, c_adr;
  logic [63:0] c_mdat_i, c_mdat_o, c_wdat, c_sdat;
  logic [7:0]  c_msel, c_sel;
  logic        c_mwe, c_mcyc, c_mstb, c_ack, c_err, c_rty, c_grant;
  logic [2:0]  c_mcti, c_cti;
  logic [1:0]  c_mbte, c_bte;
  logic        c_we, c_cyc, c_stb, c_tmo;

  wb_arbiter_qos #(.dw(32), .aw(32), .num_masters(N), .mode(0), .timeout_cycles(4)) u_a (
    .wb_clk_i (clk), .wb_rst_i (rst),
    .wbm_adr_i (m_adr), .wbm_dat_i (m_dat), .wbm_sel_i (m_sel), .wbm_we_i (m_we),
    .wbm_cyc_i (m_cyc), .wbm_stb_i (m_stb), .wbm_cti_i (m_cti), .wbm_bte_i (m_bte),
    .wbm_dat_o (a_mdat), .wbm_ack_o (a_ack), .wbm_err_o (a_err), .wbm_rty_o (a_rty),
    .wbs_adr_o (a_adr), .wbs_dat_o (a_wdat), .wbs_sel_o (a_sel), .wbs_we_o (a_we),
    .wbs_cyc_o (a_cyc), .wbs_stb_o (a_stb), .wbs_cti_o (a_cti), .wbs_bte_o (a_bte),
    .wbs_dat_i (a_sdat), .wbs_ack_i (a_sack), .wbs_err_i (a_serr), .wbs_rty_i (a_srty),
    .grant_o (a_grant), .timeout_o (a_tmo)
  );

  wb_arbiter_qos #(.dw(32), .aw(32), .num_masters(N), .mode(1), .timeout_cycles(0)) u_b (
    .wb_clk_i (clk), .wb_rst_i (rst),
    .wbm_adr_i (m_adr), .wbm_dat_i (m_dat), .wbm_sel_i (m_sel), .wbm_we_i (m_we),
    .wbm_cyc_i (m_cyc), .wbm_stb_i (m_stb), .wbm_cti_i (m_cti), .wbm_bte_i (m_bte),
    .wbm_dat_o (b_mdat), .wbm_ack_o (b_ack), .wbm_err_o (b_err), .wbm_rty_o (b_rty),
    .wbs_adr_o (b_adr), .wbs_dat_o (b_wdat), .wbs_sel_o (b_sel), .wbs_we_o (b_we),
    .wbs_cyc_o (b_cyc), .wbs_stb_o (b_stb), .wbs_cti_o (b_cti), .wbs_bte_o (b_bte),
    .wbs_dat_i (b_sdat), .wbs_ack_i (b_sack), .wbs_err_i (b_serr), .wbs_rty_i (b_srty),
    .grant_o (b_grant), .timeout_o (b_tmo)
  );

  wb_arbiter_qos #(.dw(64), .aw(32), .num_masters(1), .mode(0), .timeout_cycles(0)) u_c (
    .wb_clk_i (clk), .wb_rst_i (rst),
    .wbm_adr_i (c_madr), .wbm_dat_i (c_mdat_i), .wbm_sel_i (c_msel), .wbm_we_i (c_mwe),
    .wbm_cyc_i (c_mcyc), .wbm_stb_i (c_mstb), .wbm_cti_i (c_mcti), .wbm_bte_i (c_mbte),
    .wbm_dat_o (c_mdat_o), .wbm_ack_o (c_ack), .wbm_err_o (c_err), .wbm_rty_o (c_rty),
    .wbs_adr_o (c_adr), .wbs_dat_o (c_wdat), .wbs_sel_o (c_sel), .wbs_we_o (c_we),
    .wbs_cyc_o (c_cyc), .wbs_stb_o (c_stb), .wbs_cti_o (c_cti), .wbs_bte_o (c_bte),
    .wbs_dat_i (c_sdat), .wbs_ack_i (1'b0), .wbs_err_i (1'b0), .wbs_rty_i (1'b0),
    .grant_o (c_grant), .timeout_o (c_tmo)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One RR burst of 5 acked beats by master m, its cyc drop, then the idle gap.
  task automatic rr_burst(input int m);
    logic [N-1:0] oh;
    oh = N'(1 << m);
    for (int b = 0; b < 5; b++) begin
      m_cti[m*3 +: 3] = (b < 4) ? 3'b010 : 3'b111;
      a_sack = 1'b1;
      #1;
      check("rr_grant", a_grant, oh);
      check("rr_cyc", a_cyc, 1'b1);
      check("rr_cti", a_cti, (b < 4) ? 3'b010 : 3'b111);
      check("rr_ack", a_ack, oh);
      check("rr_adr", a_adr, 32'h1000 * (m + 1));
      step();
    end
    a_sack = 1'b0;
    m_cyc[m] = 1'b0;
    m_stb[m] = 1'b0;
    #1;
    check("rr_drop_cyc", a_cyc, 1'b0);
    check("rr_drop_ack", a_ack, 3'b000);
    step();
    m_cyc[m] = 1'b1;
    m_stb[m] = 1'b1;
    m_cti[m*3 +: 3] = 3'b000;
    #1;
    check("rr_gap_grant", a_grant, 3'b000);
    check("rr_gap_cyc", a_cyc, 1'b0);
    step();
  endtask

  int fired;

  initial begin
    rst = 1'b1;
    m_adr = {32'h3000, 32'h2000, 32'h1000};
    m_dat = {32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0};
    m_sel = '1; m_we = '0; m_cyc = '0; m_stb = '0; m_cti = '0; m_bte = '0;
    a_sdat = 32'h1234_5678; a_sack = 0; a_serr = 0; a_srty = 0;
    b_sdat = 32'hDEAD_BEEF; b_sack = 0; b_serr = 0; b_srty = 0;
    c_madr = 32'h8000; c_mdat_i = 64'h0123_4567_89AB_CDEF; c_msel = 8'hA5;
    c_mwe = 0; c_mcyc = 0; c_mstb = 0; c_mcti = 0; c_mbte = 0; c_sdat = '0;
    step();
    step();
    #1;
    check("rst_grant", a_grant, 3'b000);
    check("rst_cyc", a_cyc, 1'b0);
    check("rst_stb", a_stb, 1'b0);
    check("rst_tmo", a_tmo, 1'b0);
    check("rst_resp", {a_ack, a_err, a_rty}, 9'h000);
    check("rst_adr", a_adr, 32'h1000);
    step();

    // Round-robin: all three request from reset.
    rst = 1'b0;
    m_cyc = 3'b111;
    m_stb = 3'b111;
    #1;
    check("rr_first_idle", a_cyc, 1'b0);
    step();
    rr_burst(0);
    rr_burst(1);
    rr_burst(2);
    #1;
    check("rr_wrap_grant", a_grant, 3'b001);
    step();

    // Reset while busy.
    rst = 1'b1;
    #1;
    check("pre_rst_cyc", a_cyc, 1'b1);
    step();
    #1;
    check("rst_busy_cyc", a_cyc, 1'b0);
    check("rst_busy_grant", a_grant, 3'b000);
    check("rst_busy_err", a_err, 3'b000);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_idle", a_grant, 3'b000);
    step();
    #1;
    check("post_rst_grant", a_grant, 3'b001);
    m_cyc = '0;
    m_stb = '0;
    step();
    step();

    // Watchdog: slave never responds.
    m_cyc = 3'b010;
    m_stb = 3'b010;
    #1;
    check("tmo_idle", a_cyc, 1'b0);
    step();
    for (int k = 1; k <= 4; k++) begin
      #1;
      check("tmo_stall_err", a_err, 3'b000);
      check("tmo_stall_cyc", a_cyc, 1'b1);
      step();
    end
    #1;
    check("tmo_err", a_err, 3'b010);
    check("tmo_pulse", a_tmo, 1'b1);
    check("tmo_cyc", a_cyc, 1'b0);
    check("tmo_stb", a_stb, 1'b0);
    m_cyc = '0;
    m_stb = '0;
    step();
    #1;
    check("tmo_after_pulse", a_tmo, 1'b0);
    check("tmo_after_err", a_err, 3'b000);
    step();

    // Ack exactly in the 4th stalled cycle wins; counter restarts from 0.
    m_cyc = 3'b010;
    m_stb = 3'b010;
    step();
    for (int k = 1; k <= 3; k++) step();
    a_sack = 1'b1;
    #1;
    check("lim_ack", a_ack, 3'b010);
    check("lim_err", a_err, 3'b000);
    step();
    a_sack = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check("lim_no_tmo", a_tmo, 1'b0);
      check("lim_cyc", a_cyc, 1'b1);
      step();
    end
    #1;
    check("lim_restart_tmo", a_tmo, 1'b1);
    check("lim_restart_err", a_err, 3'b010);
    m_cyc = '0;
    m_stb = '0;
    step();
    step();

    // Owner drops cyc in the limit cycle: no error.
    m_cyc = 3'b010;
    m_stb = 3'b010;
    step();
    for (int k = 1; k <= 3; k++) step();
    m_cyc = '0;
    m_stb = '0;
    #1;
    check("drop_cyc", a_cyc, 1'b0);
    check("drop_err", a_err, 3'b000);
    step();
    #1;
    check("drop_no_tmo", a_tmo, 1'b0);
    check("drop_no_err", a_err, 3'b000);
    step();

    // Fixed priority: 2 and 1 together, 0 arrives mid-transfer.
    m_cyc = 3'b110;
    m_stb = 3'b110;
    #1;
    check("fx_idle", b_grant, 3'b000);
    step();
    #1;
    check("fx_first", b_grant, 3'b010);
    check("fx_wdat", b_wdat, 32'hC1C1_C1C1);
    check("fx_rdat", b_mdat, {3{32'hDEAD_BEEF}});
    step();
    m_cyc = 3'b111;
    m_stb = 3'b111;
    b_sack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("fx_nopreempt", b_grant, 3'b010);
      check("fx_ack", b_ack, 3'b010);
      step();
    end
    b_sack = 1'b0;
    m_cyc = 3'b101;
    m_stb = 3'b101;
    #1;
    check("fx_drop1", b_cyc, 1'b0);
    step();
    #1;
    check("fx_gap1", b_grant, 3'b000);
    step();
    #1;
    check("fx_second", b_grant, 3'b001);
    check("fx_adr0", b_adr, 32'h1000);
    step();
    m_cyc = 3'b100;
    m_stb = 3'b100;
    #1;
    check("fx_drop0", b_cyc, 1'b0);
    step();
    #1;
    check("fx_gap0", b_grant, 3'b000);
    step();
    #1;
    check("fx_third", b_grant, 3'b100);
    m_cyc = '0;
    m_stb = '0;
    step();
    step();

    // Single master, 64-bit data, watchdog disabled.
    c_mcyc = 1'b1;
    c_mstb = 1'b1;
    #1;
    check("c_latency", c_cyc, 1'b0);
    step();
    #1;
    check("c_grant", c_grant, 1'b1);
    check("c_sel", c_sel, 8'hA5);
    check("c_wdat", c_wdat, 64'h0123_4567_89AB_CDEF);
    fired = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (c_tmo || c_err) fired++;
    end
    check("c_wdog_disabled", fired, 0);
    check("c_still_busy", c_cyc, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_qos.md
# wb_arbiter_qos

Parametrised Wishbone B4 arbiter that multiplexes `num_masters` masters onto one slave port, successor to the plain round-robin arbiter in the user-project interconnect. It adds a selectable arbitration mode (round-robin or fixed priority), byte-select width derived from `dw`, and a per-transaction watchdog that terminates a stalled cycle with an error to the owning master. It sits between the CPU/DMA masters and the address decoder (`wb_mux`) inside the user project area.

## Interface
- `dw`, 32: data width; multiple of 8.
- `aw`, 32: address width.
- `num_masters`, 2: number of masters, 1..16.
- `mode`, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `timeout_cycles`, 255: stall cycles before watchdog error, 1..65535; 0 disables the watchdog.
- Clock/reset: one clock; reset is synchronous and active-high.
- `wb_clk_i` in 1: clock.
- `wb_rst_i` in 1: synchronous active-high reset.
- `wbm_adr_i`/`wbm_dat_i`/`wbm_sel_i` in `num_masters*aw`/`num_masters*dw`/`num_masters*dw/8`: packed master address, write data, byte select.
- `wbm_we_i`, `wbm_cyc_i`, `wbm_stb_i` in `num_masters`: per-master control.
- `wbm_cti_i`/`wbm_bte_i` in `num_masters*3`/`num_masters*2`: burst tags.
- `wbm_dat_o` out `num_masters*dw`: slave read data replicated.
- `wbm_ack_o`, `wbm_err_o`, `wbm_rty_o` out `num_masters`: per-master termination.
- `wbs_adr_o`, `wbs_dat_o`, `wbs_sel_o`, `wbs_we_o`, `wbs_cyc_o`, `wbs_stb_o`, `wbs_cti_o`, `wbs_bte_o` out (`aw`, `dw`, `dw/8`, 1, 1, 1, 3, 2): slave port.
- `wbs_dat_i` in `dw`; `wbs_ack_i`, `wbs_err_i`, `wbs_rty_i` in 1: slave response.
- `grant_o` out `num_masters`: one-hot registered owner, zero when idle.
- `timeout_o` out 1: one-cycle pulse when the watchdog fires.

## Operation
- FSM states: IDLE, BUSY, TMO.
- IDLE: if any `wbm_cyc_i` is set, pick a winner, register `owner`, go to BUSY. RR picks the first requester at or after `last+1` (wrapping); fixed mode picks the lowest index. With no request, remain in IDLE.
- BUSY: slave outputs are muxed from `owner`. `wbs_cyc_o = wbm_cyc_i[owner]`, `wbs_stb_o = wbm_stb_i[owner]`. Slave `ack`/`err`/`rty` are routed only to bit `owner`. Ownership is held across bursts and idle stb gaps for as long as the owner's cyc stays high. When the owner drops cyc: set `last <= owner`, go to IDLE.
- Watchdog counter (16 bit): cleared on entry to BUSY and whenever `wbs_ack_i|wbs_err_i|wbs_rty_i`. It increments while `wbs_stb_o` is high with no response, and holds while stb is low. When it reaches `timeout_cycles` in BUSY, go to TMO.
- TMO (exactly one cycle): `wbs_cyc_o`/`wbs_stb_o` forced 0, `wbm_err_o[owner]=1`, `timeout_o=1`, `last <= owner`, then go to IDLE.
- Simultaneous events:
  - A slave response on the cycle the count would hit the limit wins: it is forwarded and the counter is cleared, with no TMO.
  - If the owner drops cyc in the limit cycle, the FSM goes to IDLE and no error is issued.
- `num_masters=1`: the select is 1 bit, and arbitration degenerates to grant-on-cyc.
- `wbm_dat_o` is unconditionally replicated. Acknowledges to non-owners are always 0.

## Timing
- Reset values:
  - state IDLE, `owner=0`, `last=num_masters-1` (so RR favours master 0 first), counter 0.
  - `grant_o=0`, `timeout_o=0`, `wbs_cyc_o=0`, `wbs_stb_o=0`, and all `wbm_ack_o`/`wbm_err_o`/`wbm_rty_o` 0.
  - Muxed data/address outputs show master 0's inputs.
- Grant latency: the slave sees `wbs_cyc_o` one cycle after the requester's cyc is first seen high in IDLE.
- Re-arbitration: after the owner drops cyc, there is one IDLE cycle, then the next grant. The minimum gap between owners on the slave is therefore 2 cycles with cyc low.
- Responses are combinational slave-to-master, with zero added latency.
- Reset asserted mid-transaction: the next edge returns to IDLE. No termination is issued to the interrupted master.

## Structure
- Package `wb_arb_pkg`: FSM state enum, `MODE_RR`/`MODE_FIXED` constants, watchdog counter width (16).
- Sub-module `wb_arb_pick`: combinational winner selection.
  - Inputs: `req`, `last`, `mode`. Outputs: `valid` and encoded `idx`.
  - It uses a doubled-vector rotate for RR.
- The top level holds the FSM, the owner/last registers, the watchdog, and the muxes.

## Test plan
- RR, 3 masters, all cyc high from reset: grants go 0,1,2,0. Each holds for its full burst (CTI 010 ×4, then 111). There is a 1-cycle idle gap between owners.
- Fixed mode, masters 2 and 1 request together, then master 0 requests mid-transfer: master 1 is granted first and is not preempted, then master 0, then master 2.
- `timeout_cycles=4`, slave never acks: `wbm_err_o[owner]` and `timeout_o` pulse in the 5th stb cycle. `wbs_cyc_o` is 0 in that cycle, then the FSM returns to IDLE.
- `timeout_cycles=4`, ack arrives exactly in the 4th stalled cycle: the ack is forwarded and there is no error. The next transfer's counter starts from 0.
- Reset asserted in BUSY: the next cycle shows `wbs_cyc_o=0` and `grant_o=0`. The first post-reset RR grant goes to master 0.
- `dw=64`, `num_masters=1`: `wbs_sel_o` is 8 bits wide and passes master 0's 0xA5 through. The watchdog is disabled with `timeout_cycles=0` and never fires after 1000 stalled cycles.
